regfile_access_arbiter: RTL
===========================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares the register file write port and read port 2 between the core and a debug/loader requester.
//  - Core: writeback stage. Debug: UART monitor / board switches.
//  - Core writeback always wins, except after starvation or for debug reads; then core_stall freezes the core.
//  - Sits between the core datapath and the register file.
//  - The register file writes on negedge, so a write granted in cycle N commits mid-cycle N.
// PARAMETERS
//  DATA_W        32  datapath width
//  ADDR_W        5   register index width
//  STARVE_LIMIT  8   consecutive WAIT cycles lost to core writes before a forced stall (>=1)
// PORTS
//  clk          in   1       system clock; posedge for all arbiter state
//  reset        in   1       synchronous, active-high
//  core_raddr2  in   ADDR_W  core read port 2 address
//  core_we      in   1       core writeback enable
//  core_waddr   in   ADDR_W  core writeback address
//  core_wdata   in   DATA_W  core writeback data
//  core_stall   out  1       core freeze, registered; high only in state STALL
//  rf_raddr2    out  ADDR_W  to register file read port 2
//  rf_rdata2    in   DATA_W  from register file read port 2 (combinational)
//  rf_we        out  1       to register file write enable
//  rf_waddr     out  ADDR_W  to register file write address
//  rf_wdata     out  DATA_W  to register file write data
//  dbg_req      in   1       debug request; hold high with stable fields until dbg_ack
//  dbg_we       in   1       1 = write, 0 = read
//  dbg_addr     in   ADDR_W  debug register index
//  dbg_wdata    in   DATA_W  debug write data
//  dbg_ack      out  1       one-cycle completion pulse
//  dbg_rdata    out  DATA_W  read result; valid from dbg_ack, held until the next read
//  dbg_err      out  1       rejected access; valid with dbg_ack
// BEHAVIOUR
//  FSM states: IDLE, WAIT, STALL, ACK.
//  Reset: state=IDLE, core_stall=0, dbg_ack=0, dbg_err=0, dbg_rdata=0, starve_cnt=0, hold regs=0.
//  - Reset mid-transaction abandons it with no ack; a write already committed is not undone.
//  IDLE:
//  - dbg_req sampled only here.
//  - If high: latch we/addr/wdata into hold regs, clear starve_cnt, go to WAIT.
//  WAIT, read op: go to STALL next cycle.
//  WAIT, write op, core_we=0 this cycle: debug write issued this cycle; go to ACK.
//  WAIT, write op, core_we=1: core write passes; starve_cnt++.
//  - When starve_cnt reaches STARVE_LIMIT, go to STALL.
//  STALL:
//  - core_stall=1; core_we ignored; rf_raddr2=hold_addr.
//  - Pending write issued; for a read, dbg_rdata<=rf_rdata2 at the end of the cycle.
//  - Always exits to ACK after one cycle.
//  ACK:
//  - dbg_ack=1 for exactly one cycle; dbg_err is valid; go to IDLE.
//  - If dbg_req is still high in the following IDLE cycle, a new transaction starts.
//  Write-port mux (combinational):
//  - Debug selected in WAIT (write op, core_we=0) and in STALL (write op).
//  - Otherwise rf_we/rf_waddr/rf_wdata = core_we/core_waddr/core_wdata.
//  - rf_raddr2 = core_raddr2 outside STALL.
//  Address 0: a debug write to x0 drives rf_we=0 but still completes with dbg_ack and dbg_err=0.
//  - A debug read of x0 returns 0.
//  Latency from dbg_req rising in IDLE to dbg_ack:
//  - Uncontended write: 3 cycles.
//  - Read: 4 cycles.
//  - Starved write: 3+STARVE_LIMIT cycles.
// CONFIGURATION
//  RF_ARB_PROTECT_EN defined:
//  - Debug writes to x2 (sp) and x3 (MMIO base) are rejected: WAIT goes straight to ACK.
//  - No rf_we and no stall; dbg_err=1 with dbg_ack. Reads of x2/x3 are allowed.
//  RF_ARB_PROTECT_EN undefined: dbg_err is tied to 0 and all debug writes are performed.
// TESTING
//  1. Write x5=0xDEADBEEF with core_we=0 -> rf_we=1,waddr=5 in WAIT; dbg_ack 3 cycles after req; no stall.
//  2. Write x6=0x1234 with core_we=1 held -> 8 core writes pass; core_stall=1 for 1 cycle with the x6 write; then dbg_ack.
//  3. Read x2 after reset -> core_stall 1 cycle, rf_raddr2=2; dbg_rdata=STAK_ADDRESS at dbg_ack.
//  4. Write x0=0xFFFFFFFF -> rf_we=0 throughout; dbg_ack=1, dbg_err=0; a following read of x0 returns 0.
//  5. Reset asserted while in STALL -> next cycle IDLE, core_stall=0, dbg_ack never pulses.
//  6. With RF_ARB_PROTECT_EN, write x3=0 -> rf_we=0, dbg_ack with dbg_err=1; without the macro, x3 is written, dbg_err=0.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
// Shares the register file write port and read port 2 between the core
// writeback stage and a debug/loader requester (UART monitor, switches).
// Core writeback normally wins; a debug read, or a debug write that has lost
// STARVE_LIMIT consecutive cycles to the core, freezes the core for one cycle
// (STALL) so the debug access can use the ports.
//
// Optional feature macro: RF_ARB_PROTECT_EN
//   When defined, debug writes to x2 (sp) and x3 (MMIO base) are rejected
//   and reported through dbg_err. When undefined, dbg_err is tied low.
module regfile_access_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_raddr2,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  state_t            state;
  state_t            state_next;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [CNT_W-1:0]  starve_cnt;
  logic              protect_hit;
  logic              addr_zero;
  logic              dbg_sel;
  logic              starve_done;

`ifdef RF_ARB_PROTECT_EN
  assign protect_hit = hold_we &&
                       ((hold_addr == ADDR_W'(2)) || (hold_addr == ADDR_W'(3)));
`else
  assign protect_hit = 1'b0;
`endif

  assign addr_zero   = (hold_addr == '0);
  assign starve_done = (starve_cnt == CNT_W'(STARVE_LIMIT - 1));

  // The debug requester owns the write port when its write is issued in WAIT
  // (core idle) or in STALL (core frozen); rejected writes never take it.
  assign dbg_sel = hold_we && !protect_hit &&
                   (((state == WAIT) && !core_we) || (state == STALL));

  // State register plus the debug hold registers, starvation counter and
  // read-result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      starve_cnt <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && dbg_req) begin
        hold_we    <= dbg_we;
        hold_addr  <= dbg_addr;
        hold_wdata <= dbg_wdata;
        starve_cnt <= '0;
      end
      if ((state == WAIT) && hold_we && !protect_hit && core_we) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if ((state == STALL) && !hold_we) begin
        dbg_rdata <= addr_zero ? '0 : rf_rdata2;
      end
    end
  end

  // Next-state decision for the arbitration FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (dbg_req) state_next = WAIT;
      WAIT: begin
        if (!hold_we)         state_next = STALL;
        else if (protect_hit) state_next = ACK;
        else if (!core_we)    state_next = ACK;
        else if (starve_done) state_next = STALL;
      end
      STALL: state_next = ACK;
      ACK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port muxing: debug fields when selected, core fields otherwise; the core
  // write enable is ignored while the core is frozen.
  always_comb begin
    rf_we     = core_we && (state != STALL);
    rf_waddr  = core_waddr;
    rf_wdata  = core_wdata;
    rf_raddr2 = core_raddr2;
    if (dbg_sel) begin
      rf_we    = !addr_zero;
      rf_waddr = hold_addr;
      rf_wdata = hold_wdata;
    end
    if (state == STALL) begin
      rf_raddr2 = hold_addr;
    end
  end

  assign core_stall = (state == STALL);
  assign dbg_ack    = (state == ACK);
  assign dbg_err    = (state == ACK) && protect_hit;

endmodule
